// File: rtl/scratchpad_ctrl.sv
// Banked scratchpad: captures a full-width batch, drains writes PORTS per cycle, then
// reads PORTS/2 lanes (x+w) per cycle. `define SCRATCHPAD_PERF_EN adds perf counters.
module scratchpad_ctrl #(
    parameter int N     = 64,
    parameter int DEPTH = 65536,
    parameter int PORTS = 8,
    parameter int AW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [N-1:0]           rd_valid,
    input  logic [N-1:0][AW-1:0]   x_addr,
    input  logic [N-1:0][AW-1:0]   w_addr,
    input  logic [N-1:0]           wr_valid,
    input  logic [N-1:0][AW-1:0]   wr_addr,
    input  logic [N-1:0][31:0]     wr_data,
    output logic                   resp_valid,
    output logic [N-1:0][31:0]     x_data,
    output logic [N-1:0][31:0]     w_data,
    output logic                   addr_err
`ifdef SCRATCHPAD_PERF_EN
    ,
    output logic [31:0]            perf_rd_cnt,
    output logic [31:0]            perf_wr_cnt,
    output logic [31:0]            perf_busy_cyc
`endif
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;

    state_t                 state_q, state_d;
    logic [N-1:0]           wr_mask_q, wr_mask_d, rd_mask_q, rd_mask_d;
    logic [N-1:0]           wsel, rsel;
    logic                   req_ready_q, req_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   addr_err_q, addr_err_d;
    logic [N-1:0][31:0]     x_data_q, x_data_d, w_data_q, w_data_d;
    logic [N-1:0][31:0]     wr_data_q, wr_data_d;
    logic [N-1:0][AW-1:0]   x_addr_q, x_addr_d, w_addr_q, w_addr_d, wr_addr_q, wr_addr_d;
    logic [31:0]            mem [DEPTH];

    function automatic logic oob(input logic [AW-1:0] a);
        return (a >> IW) != '0;
    endfunction

    // Lowest-index pending lanes win the physical ports this cycle.
    always_comb begin
        int nw, nr;
        wsel = '0;
        rsel = '0;
        nw   = 0;
        nr   = 0;
        for (int i = 0; i < N; i++) begin
            if (wr_mask_q[i] && nw < PORTS) begin
                wsel[i] = 1'b1;
                nw      = nw + 1;
            end
            if (rd_mask_q[i] && nr < PORTS/2) begin
                rsel[i] = 1'b1;
                nr      = nr + 1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_mask_d    = wr_mask_q;
        rd_mask_d    = rd_mask_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        addr_err_d   = addr_err_q;
        x_data_d     = x_data_q;
        w_data_d     = w_data_q;
        x_addr_d     = x_addr_q;
        w_addr_d     = w_addr_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_mask_d   = wr_valid;
                    rd_mask_d   = rd_valid;
                    x_addr_d    = x_addr;
                    w_addr_d    = w_addr;
                    wr_addr_d   = wr_addr;
                    wr_data_d   = wr_data;
                    req_ready_d = 1'b0;
                    x_data_d    = '0;
                    w_data_d    = '0;
                    addr_err_d  = 1'b0;
                    for (int i = 0; i < N; i++) begin
                        if ((wr_valid[i] && oob(wr_addr[i])) ||
                            (rd_valid[i] && (oob(x_addr[i]) || oob(w_addr[i]))))
                            addr_err_d = 1'b1;
                    end
                    if (wr_valid != '0) begin
                        state_d = S_WRITE;
                    end else if (rd_valid != '0) begin
                        state_d = S_READ;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                wr_mask_d = wr_mask_q & ~wsel;
                if (wr_mask_d == '0) begin
                    if (rd_mask_q != '0) begin
                        state_d = S_READ;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                rd_mask_d = rd_mask_q & ~rsel;
                for (int i = 0; i < N; i++) begin
                    if (rsel[i]) begin
                        x_data_d[i] = oob(x_addr_q[i]) ? 32'h0 : mem[x_addr_q[i][IW-1:0]];
                        w_data_d[i] = oob(w_addr_q[i]) ? 32'h0 : mem[w_addr_q[i][IW-1:0]];
                    end
                end
                if (rd_mask_d == '0) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                end
            end
            S_RESP: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_mask_q    <= '0;
            rd_mask_q    <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            x_data_q     <= '0;
            w_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            wr_mask_q    <= wr_mask_d;
            rd_mask_q    <= rd_mask_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            addr_err_q   <= addr_err_d;
            x_data_q     <= x_data_d;
            w_data_q     <= w_data_d;
        end
    end

    // Batch capture only matters while the masks are live, so it needs no reset.
    always_ff @(posedge clk) begin
        x_addr_q  <= x_addr_d;
        w_addr_q  <= w_addr_d;
        wr_addr_q <= wr_addr_d;
        wr_data_q <= wr_data_d;
    end

    // Ascending lane order lets the highest lane win a same-cycle address collision.
    always_ff @(posedge clk) begin
        if (state_q == S_WRITE) begin
            for (int i = 0; i < N; i++) begin
                if (wsel[i] && !oob(wr_addr_q[i]))
                    mem[wr_addr_q[i][IW-1:0]] <= wr_data_q[i];
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign addr_err   = addr_err_q;
    assign x_data     = x_data_q;
    assign w_data     = w_data_q;

`ifdef SCRATCHPAD_PERF_EN
    logic [31:0] perf_rd_q, perf_rd_d, perf_wr_q, perf_wr_d, perf_busy_q, perf_busy_d;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input int b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_comb begin
        int nrd, nwr;
        nrd = 0;
        nwr = 0;
        for (int i = 0; i < N; i++) begin
            if (state_q == S_READ && rsel[i]) nrd = nrd + 1;
            if (state_q == S_WRITE && wsel[i] && !oob(wr_addr_q[i])) nwr = nwr + 1;
        end
        perf_rd_d   = sat_add(perf_rd_q, nrd);
        perf_wr_d   = sat_add(perf_wr_q, nwr);
        perf_busy_d = sat_add(perf_busy_q, req_ready_q ? 0 : 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_rd_q   <= '0;
            perf_wr_q   <= '0;
            perf_busy_q <= '0;
        end else begin
            perf_rd_q   <= perf_rd_d;
            perf_wr_q   <= perf_wr_d;
            perf_busy_q <= perf_busy_d;
        end
    end

    assign perf_rd_cnt   = perf_rd_q;
    assign perf_wr_cnt   = perf_wr_q;
    assign perf_busy_cyc = perf_busy_q;
`endif
endmodule

// File: tb/tb_scratchpad_ctrl.sv
// Randomized bench for scratchpad_ctrl: a batch-level memory model predicts data,
// addr_err and response timing; a negedge monitor compares every cycle.
module tb_scratchpad_ctrl;
    localparam int N     = 64;
    localparam int DEPTH = 65536;
    localparam int PORTS = 8;
    localparam int AW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready, resp_valid, addr_err;
    logic [N-1:0]          rd_valid = '0, wr_valid = '0;
    logic [N-1:0][AW-1:0]  x_addr = '0, w_addr = '0, wr_addr = '0;
    logic [N-1:0][31:0]    wr_data = '0;
    logic [N-1:0][31:0]    x_data, w_data;
`ifdef SCRATCHPAD_PERF_EN
    logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_busy_cyc;
`endif

    scratchpad_ctrl #(.N(N), .DEPTH(DEPTH), .PORTS(PORTS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .rd_valid(rd_valid), .x_addr(x_addr), .w_addr(w_addr),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .resp_valid(resp_valid), .x_data(x_data), .w_data(w_data), .addr_err(addr_err)
`ifdef SCRATCHPAD_PERF_EN
        , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_busy_cyc(perf_busy_cyc)
`endif
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    bit mon_en = 1'b0, have_batch = 1'b0;
    int b_acc = 0, b_len = 0, rv_seen = -1;
    logic [N-1:0][31:0] exp_x = '0, exp_w = '0;
    logic exp_err = 1'b0;
    bit [31:0] mm [int unsigned];

    logic [N-1:0]         s_rdv, s_wrv;
    logic [N-1:0][AW-1:0] s_xa, s_wa, s_wra;
    logic [N-1:0][31:0]   s_wd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic chk_lanes(input string nm, input logic [N-1:0][31:0] got,
                             input logic [N-1:0][31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            for (int i = 0; i < N; i++)
                if (got[i] !== want[i]) begin
                    $display("FAIL %s lane %0d: got %0h want %0h (cyc %0d)", nm, i, got[i], want[i], cyc);
                    break;
                end
        end
    endtask

    // Every cycle: handshake timing from the model, data/addr_err once the batch is due.
    always @(negedge clk) begin : monitor
        bit due;
        if (mon_en) begin
            due = !have_batch || (cyc >= b_acc + b_len - 1);
            chk("resp_valid", 32'(resp_valid), 32'(have_batch && cyc == b_acc + b_len - 1));
            chk("req_ready", 32'(req_ready), 32'(!have_batch || cyc >= b_acc + b_len));
            if (resp_valid === 1'b1 && rv_seen < 0) rv_seen = cyc;
            if (due) begin
                chk_lanes("x_data", x_data, exp_x);
                chk_lanes("w_data", w_data, exp_w);
                chk("addr_err", 32'(addr_err), 32'(exp_err));
            end
        end
    end

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(15) == 0) return $urandom() | 32'h0001_0000;
        return AW'($urandom_range(255));
    endfunction

    function automatic int pick_density();
        case ($urandom_range(3))
            0: return 0;
            1: return 10;
            2: return 50;
            default: return 100;
        endcase
    endfunction

    task automatic clear_stage();
        s_rdv = '0; s_wrv = '0; s_xa = '0; s_wa = '0; s_wra = '0; s_wd = '0;
    endtask

    task automatic rand_stage();
        int pw, pr;
        pw = pick_density();
        pr = pick_density();
        for (int i = 0; i < N; i++) begin
            s_wrv[i] = ($urandom_range(99) < pw);
            s_rdv[i] = ($urandom_range(99) < pr);
            s_wra[i] = rnd_addr();
            s_xa[i]  = rnd_addr();
            s_wa[i]  = rnd_addr();
            s_wd[i]  = $urandom();
        end
    endtask

    task automatic do_abort();
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk_lanes("abort_x", x_data, '0);
        chk_lanes("abort_w", w_data, '0);
        chk("abort_addr_err", 32'(addr_err), 32'd0);
        mon_en = 1'b0; have_batch = 1'b0; exp_x = '0; exp_w = '0; exp_err = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    // Issue the staged batch; the model applies all writes in lane order, then reads.
    task automatic batch(input bit hold, input int lit_lat, input int abort_at);
        int nw, nr, acc;
        nw = $countones(s_wrv);
        nr = $countones(s_rdv);
        @(negedge clk);
        #1;
        rd_valid = s_rdv; wr_valid = s_wrv; x_addr = s_xa; w_addr = s_wa;
        wr_addr = s_wra; wr_data = s_wd; req_valid = 1'b1;
        acc = cyc + 1;
        exp_err = 1'b0;
        for (int i = 0; i < N; i++)
            if (s_wrv[i]) begin
                if (s_wra[i] > 32'hFFFF) exp_err = 1'b1;
                else mm[s_wra[i]] = s_wd[i];
            end
        for (int i = 0; i < N; i++) begin
            exp_x[i] = '0;
            exp_w[i] = '0;
            if (s_rdv[i]) begin
                if (s_xa[i] > 32'hFFFF) exp_err = 1'b1; else exp_x[i] = mm[s_xa[i]];
                if (s_wa[i] > 32'hFFFF) exp_err = 1'b1; else exp_w[i] = mm[s_wa[i]];
            end
        end
        b_acc = acc;
        b_len = 1 + (nw + PORTS - 1) / PORTS + (nr + PORTS/2 - 1) / (PORTS/2);
        rv_seen = -1;
        have_batch = 1'b1;
        @(negedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd_valid[i] = 1'($urandom_range(1));
            wr_valid[i] = 1'($urandom_range(1));
            x_addr[i] = $urandom(); w_addr[i] = $urandom();
            wr_addr[i] = $urandom(); wr_data[i] = $urandom();
        end
        while (cyc < acc + b_len) begin
            if (abort_at > 0 && cyc == acc + abort_at) begin
                do_abort();
                return;
            end
            @(negedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (lit_lat > 0) chk("latency", 32'(rv_seen - acc + 1), 32'(lit_lat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk_lanes("rst_x", x_data, '0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Full-width write then read-back with reversed w addresses.
        clear_stage();
        for (int i = 0; i < N; i++) begin
            s_wrv[i] = 1'b1; s_wra[i] = AW'(i); s_wd[i] = 32'(i + 1);
        end
        batch(1'b0, 9, 0);
        clear_stage();
        for (int i = 0; i < N; i++) begin
            s_rdv[i] = 1'b1; s_xa[i] = AW'(i); s_wa[i] = AW'(63 - i);
        end
        batch(1'b0, 17, 0);
        for (int i = 0; i < N; i += 9) begin
            chk("wb_x", x_data[i], 32'(i + 1));
            chk("wb_w", w_data[i], 32'(64 - i));
        end
`ifdef SCRATCHPAD_PERF_EN
        chk("perf_wr", perf_wr_cnt, 32'd64);
        chk("perf_rd", perf_rd_cnt, 32'd64);
        chk("perf_busy", perf_busy_cyc, 32'd26);
`endif

        // Fill the rest of the random-address window so every later read is defined.
        for (int b = 1; b < 4; b++) begin
            clear_stage();
            for (int i = 0; i < N; i++) begin
                s_wrv[i] = 1'b1; s_wra[i] = AW'(b * 64 + i); s_wd[i] = $urandom();
            end
            batch(1'b0, 9, 0);
        end

        clear_stage();
        s_wrv[0] = 1'b1; s_wra[0] = 32'h10; s_wd[0] = 32'hDEAD_BEEF;
        s_rdv[5] = 1'b1; s_xa[5] = 32'h10; s_wa[5] = 32'h11;
        batch(1'b0, 3, 0);
        chk("raw_x5", x_data[5], 32'hDEAD_BEEF);

        clear_stage();
        s_wrv[3] = 1'b1; s_wra[3] = 32'h20; s_wd[3] = 32'hA;
        s_wrv[7] = 1'b1; s_wra[7] = 32'h20; s_wd[7] = 32'hB;
        batch(1'b0, 2, 0);
        clear_stage();
        s_rdv[0] = 1'b1; s_xa[0] = 32'h20; s_wa[0] = 32'h20;
        batch(1'b0, 2, 0);
        chk("dup_x0", x_data[0], 32'hB);

        clear_stage();
        batch(1'b0, 1, 0);
        chk("empty_x0", x_data[0], 32'h0);

        clear_stage();
        s_rdv[2] = 1'b1; s_xa[2] = 32'h0001_0000; s_wa[2] = 32'h5;
        batch(1'b0, 2, 0);
        chk("oob_x2", x_data[2], 32'h0);
        chk("oob_err", 32'(addr_err), 32'd1);
        clear_stage();
        s_rdv[2] = 1'b1; s_xa[2] = 32'h5; s_wa[2] = 32'h6;
        batch(1'b0, 2, 0);
        chk("oob_err_clear", 32'(addr_err), 32'd0);

        for (int k = 0; k < 4; k++) begin
            rand_stage();
            batch(1'b1, 0, 0);
        end
        for (int k = 0; k < 30; k++) begin
            rand_stage();
            batch(k % 5 == 0, 0, 0);
        end

        // Abort mid-READ, then confirm the batch's writes survived.
        clear_stage();
        for (int i = 0; i < 6; i++) begin
            s_wrv[i] = 1'b1; s_wra[i] = AW'($urandom_range(255)); s_wd[i] = $urandom();
        end
        for (int i = 0; i < N; i++) begin
            s_rdv[i] = 1'b1; s_xa[i] = AW'($urandom_range(255)); s_wa[i] = AW'($urandom_range(255));
        end
        batch(1'b0, 0, 5);
        s_rdv = s_wrv; s_xa = s_wra; s_wa = s_wra; s_wrv = '0;
        batch(1'b0, 0, 0);

        rand_stage();
        batch(1'b0, 0, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scratchpad_ctrl.md
Name: scratchpad_ctrl

Overview:
- Banked scratchpad controller that services the systolic top's per-lane scratchpad request vectors: N operand-read lanes (x and w) plus N write-back lanes.
- Replaces the behavioural scratchpad model with synthesizable storage of DEPTH 32-bit words.
- Has PORTS physical accesses per cycle, so a full-width batch is serialized over several cycles and returned with a single response handshake.

Parameters:
- N, 64, number of request lanes.
- DEPTH, 65536, words of storage (power of two).
- PORTS, 8, physical accesses per cycle. Must be even and >= 2.
- AW, 32, address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  batch request strobe.
- req_ready  out  1  controller can accept a batch.
- rd_valid  in  N  per-lane read enable (fetches both x and w).
- x_addr  in  N*AW  per-lane x operand address.
- w_addr  in  N*AW  per-lane w operand address.
- wr_valid  in  N  per-lane write enable.
- wr_addr  in  N*AW  per-lane write address.
- wr_data  in  N*32  per-lane write data.
- resp_valid  out  1  batch complete, one-cycle pulse.
- x_data  out  N*32  per-lane x result.
- w_data  out  N*32  per-lane w result.
- addr_err  out  1  batch contained an out-of-range address; valid with resp_valid.

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, x_data=0, w_data=0, addr_err=0, pending masks cleared.
  - Storage contents are not reset.
  - Reset mid-batch aborts the batch: no resp_valid, and writes already performed remain.
- Accept: a batch is accepted on a clk edge where req_valid && req_ready. All input vectors are captured into internal registers; inputs are don't-care afterwards.
  - req_ready=0 from the cycle after accept until the cycle after resp_valid.
- Next state after accept: WRITE if wr_valid!=0, else READ if rd_valid!=0, else RESP.
- WRITE state:
  - Each cycle performs up to PORTS pending writes, lowest lane index first, and clears their pending bits.
  - Exits to READ (or RESP if no reads) on the cycle the mask empties.
  - Writes complete before any read, so a read in the same batch sees new data.
  - Duplicate write addresses in one batch: the highest lane index wins.
- READ state:
  - Each cycle services up to PORTS/2 pending read lanes, lowest index first.
  - Each serviced lane costs 2 accesses (x and w). Results are registered into x_data[i]/w_data[i].
  - Lanes with rd_valid=0 produce 0.
  - Exits to RESP when the mask empties.
- RESP state: resp_valid=1 for exactly one cycle, then IDLE.
  - x_data/w_data/addr_err hold stable until the next accepted batch updates them.
- Latency from accept edge to resp_valid high: 1 + ceil(nw/PORTS) + ceil(nr/(PORTS/2)) cycles.
  - nw and nr are the popcounts of the write and read masks.
  - An empty batch gives resp_valid on the cycle after accept.
- Addressing: index = addr[log2(DEPTH)-1:0]. An address is out of range if any higher bit is set.
  - Out-of-range read returns 0.
  - Out-of-range write is dropped.
  - Either case sets addr_err for that batch; addr_err clears on the next accept.
- req_valid while req_ready=0 is ignored; there is no queuing.

Optional Feature:
- SCRATCHPAD_PERF_EN.
- When defined, adds outputs perf_rd_cnt[31:0], perf_wr_cnt[31:0] and perf_busy_cyc[31:0].
  - perf_rd_cnt: lane reads serviced.
  - perf_wr_cnt: writes performed (in-range only).
  - perf_busy_cyc: cycles with req_ready=0.
  - All three reset to 0 on rst, saturate at 0xFFFFFFFF, and are never cleared otherwise.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Write/read-back: batch 1 with wr_valid=all, wr_addr[i]=i, wr_data[i]=i+1; batch 2 with rd_valid=all, x_addr[i]=i, w_addr[i]=63-i.
  - Expect x_data[i]=i+1 and w_data[i]=64-i.
  - Batch 1 resp_valid 9 cycles after accept; batch 2 resp_valid 17 cycles after accept (N=64, PORTS=8).
- Same-batch RAW: lane 0 writes 0xDEADBEEF to 0x10, lane 5 reads x_addr=0x10 in the same batch -> x_data[5]=0xDEADBEEF.
- Duplicate writes: lanes 3 and 7 both write address 0x20 with 0xA and 0xB -> later read of 0x20 returns 0xB.
- Boundaries:
  - Empty batch -> resp_valid exactly 1 cycle after accept, data all 0.
  - Read at address 0x10000 (DEPTH=65536) -> x_data=0, addr_err=1.
  - A following in-range batch -> addr_err=0.
- Backpressure and reset:
  - req_valid held high during a batch -> only one resp_valid per accepted batch; req_ready returns to 1 the cycle after resp_valid.
  - rst asserted mid-READ -> req_ready=1, resp_valid=0, outputs 0 immediately; data written before the abort is still readable afterwards.
- SCRATCHPAD_PERF_EN: after the first scenario, perf_wr_cnt=64, perf_rd_cnt=64, perf_busy_cyc=26.
